// File: rtl/mem_stage_lsu.sv
// MEM stage with EX->MEM register, load alignment/extension and a variable-latency load handshake.
// Optional forwarding bus to ID is enabled by defining MEM_FWD_EN.
module mem_stage_lsu #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned RA_W    = 5,
  parameter int unsigned STALL_W = 6,
  parameter int unsigned MEM_IDX = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                ex_valid,
  input  logic [PC_W-1:0]     ex_pc,
  input  logic                ex_rf_we,
  input  logic [RA_W-1:0]     ex_rf_waddr,
  input  logic [DATA_W-1:0]   ex_result,
  input  logic                ex_is_load,
  input  logic [2:0]          ex_load_op,
  input  logic                data_rvalid,
  input  logic [DATA_W-1:0]   data_rdata,
  output logic                stallreq_mem,
  output logic                wb_valid,
  output logic [PC_W-1:0]     wb_pc,
  output logic                wb_rf_we,
  output logic [RA_W-1:0]     wb_rf_waddr,
  output logic [DATA_W-1:0]   wb_rf_wdata,
  output logic                mem_ale
`ifdef MEM_FWD_EN
  ,
  output logic [RA_W+DATA_W:0] mem_to_id,
  output logic                 mem_load_busy,
  output logic [RA_W-1:0]      mem_busy_waddr
`endif
);

  localparam int unsigned OffW = $clog2(DATA_W / 8);

  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpLd  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpLhu = 3'b101;
  localparam logic [2:0] OpLwu = 3'b110;

  typedef enum logic [1:0] {StIdle, StWait, StHeld} state_e;

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              rf_we_q, rf_we_d;
  logic [RA_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        op_q, op_d;
  logic [OffW-1:0]   off_q, off_d;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic              stall_mem, stall_wb;
  logic              misalign, load_pend;
  logic [DATA_W-1:0] lane, load_ext;
  logic              unused_stall;

  assign stall_mem    = stall[MEM_IDX];
  assign stall_wb     = stall[MEM_IDX+1];
  assign unused_stall = ^stall;

  // Pipeline register next state: flush, then bubble, then advance, else hold.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    rf_we_d   = rf_we_q;
    waddr_d   = waddr_q;
    result_d  = result_q;
    is_load_d = is_load_q;
    op_d      = op_q;
    off_d     = off_q;
    if (flush || (stall_mem && !stall_wb)) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      rf_we_d   = 1'b0;
      waddr_d   = '0;
      result_d  = '0;
      is_load_d = 1'b0;
      op_d      = '0;
      off_d     = '0;
    end else if (!stall_mem) begin
      valid_d   = ex_valid;
      pc_d      = ex_pc;
      rf_we_d   = ex_rf_we;
      waddr_d   = ex_rf_waddr;
      result_d  = ex_result;
      is_load_d = ex_is_load;
      op_d      = ex_load_op;
      off_d     = ex_result[OffW-1:0];
    end
  end

  always_comb begin
    misalign = 1'b0;
    case (op_q)
      OpLb, OpLbu: misalign = 1'b0;
      OpLh, OpLhu: misalign = off_q[0];
      OpLw:        misalign = |off_q[1:0];
      OpLwu:       misalign = (DATA_W != 64) || (|off_q[1:0]);
      OpLd:        misalign = (DATA_W != 64) || (|off_q);
      default:     misalign = 1'b1;
    endcase
  end

  assign lane = data_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = data_rdata;
    case (op_q)
      OpLb:    load_ext = DATA_W'($signed(lane[7:0]));
      OpLh:    load_ext = DATA_W'($signed(lane[15:0]));
      OpLw:    load_ext = DATA_W'($signed(lane[31:0]));
      OpLbu:   load_ext = DATA_W'(lane[7:0]);
      OpLhu:   load_ext = DATA_W'(lane[15:0]);
      OpLwu:   load_ext = DATA_W'(lane[31:0]);
      default: load_ext = data_rdata;
    endcase
  end

  assign load_pend = valid_q & is_load_q & ~misalign;
  assign mem_ale   = valid_q & is_load_q & misalign;

  // A response arriving while MEM is stalled is parked in buf_q until the stall lifts.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    unique case (state_q)
      StIdle: begin
        if (load_pend && data_rvalid && stall_mem) begin
          buf_d   = load_ext;
          state_d = StHeld;
        end else if (load_pend && !data_rvalid) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (data_rvalid) begin
          if (stall_mem) begin
            buf_d   = load_ext;
            state_d = StHeld;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHeld: begin
        if (!stall_mem) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      rf_we_q   <= 1'b0;
      waddr_q   <= '0;
      result_q  <= '0;
      is_load_q <= 1'b0;
      op_q      <= '0;
      off_q     <= '0;
      state_q   <= StIdle;
      buf_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      rf_we_q   <= rf_we_d;
      waddr_q   <= waddr_d;
      result_q  <= result_d;
      is_load_q <= is_load_d;
      op_q      <= op_d;
      off_q     <= off_d;
      state_q   <= state_d;
      buf_q     <= buf_d;
    end
  end

  assign stallreq_mem = ~data_rvalid &
                        ((state_q == StWait) | ((state_q == StIdle) & load_pend));
  assign wb_valid     = valid_q & ~stallreq_mem;
  assign wb_pc        = pc_q;
  assign wb_rf_waddr  = waddr_q;
  assign wb_rf_we     = rf_we_q & wb_valid & ~mem_ale;
  assign wb_rf_wdata  = !is_load_q           ? result_q :
                        (state_q == StHeld)  ? buf_q    : load_ext;

`ifdef MEM_FWD_EN
  assign mem_to_id      = {wb_rf_we, wb_rf_waddr, wb_rf_wdata};
  assign mem_load_busy  = stallreq_mem;
  assign mem_busy_waddr = stallreq_mem ? waddr_q : '0;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (default 32-bit build).
module tb_mem_stage_lsu;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LD  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_LHU = 3'b101;
  localparam logic [5:0] S_HOLD = 6'b011111;
  localparam logic [5:0] S_BUB  = 6'b001111;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_rf_we;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_load_op;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        stallreq_mem;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        wb_rf_we;
  logic [4:0]  wb_rf_waddr;
  logic [31:0] wb_rf_wdata;
  logic        mem_ale;

  int total = 0;
  int bad   = 0;

  mem_stage_lsu dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_rf_we     (ex_rf_we),
    .ex_rf_waddr  (ex_rf_waddr),
    .ex_result    (ex_result),
    .ex_is_load   (ex_is_load),
    .ex_load_op   (ex_load_op),
    .data_rvalid  (data_rvalid),
    .data_rdata   (data_rdata),
    .stallreq_mem (stallreq_mem),
    .wb_valid     (wb_valid),
    .wb_pc        (wb_pc),
    .wb_rf_we     (wb_rf_we),
    .wb_rf_waddr  (wb_rf_waddr),
    .wb_rf_wdata  (wb_rf_wdata),
    .mem_ale      (mem_ale)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [31:0] pc, input logic we,
                       input logic [4:0] wa, input logic [31:0] res, input logic ld,
                       input logic [2:0] op);
    ex_valid    = v;
    ex_pc       = pc;
    ex_rf_we    = we;
    ex_rf_waddr = wa;
    ex_result   = res;
    ex_is_load  = ld;
    ex_load_op  = op;
  endtask

  task automatic nop();
    issue(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 3'b000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
    nop();
    tick(); tick();
    chk("rst_stallreq", {31'b0, stallreq_mem}, 32'h0);
    chk("rst_valid", {31'b0, wb_valid}, 32'h0);
    chk("rst_wdata", wb_rf_wdata, 32'h0);
    chk("rst_ale", {31'b0, mem_ale}, 32'h0);
    rst = 1'b0;

    // ALU result passes straight through
    issue(1'b1, 32'h100, 1'b1, 5'd5, 32'h0000_1234, 1'b0, OP_LB);
    tick(); nop(); #1;
    chk("add_valid", {31'b0, wb_valid}, 32'h1);
    chk("add_we", {31'b0, wb_rf_we}, 32'h1);
    chk("add_waddr", {27'b0, wb_rf_waddr}, 32'd5);
    chk("add_wdata", wb_rf_wdata, 32'h0000_1234);
    chk("add_pc", wb_pc, 32'h100);

    // stall[MEM]=1, stall[WB]=0 inserts a bubble
    issue(1'b1, 32'h104, 1'b1, 5'd6, 32'h55, 1'b0, OP_LB);
    tick(); nop(); stall = S_BUB; #1;
    chk("bub_pre_valid", {31'b0, wb_valid}, 32'h1);
    tick(); stall = '0; #1;
    chk("bub_valid", {31'b0, wb_valid}, 32'h0);

    // zero-wait byte and half loads
    issue(1'b1, 32'h108, 1'b1, 5'd6, 32'h0000_1003, 1'b1, OP_LB);
    tick(); data_rvalid = 1'b1; data_rdata = 32'h80AA_BBCC; #1;
    chk("lb_stallreq", {31'b0, stallreq_mem}, 32'h0);
    chk("lb_wdata", wb_rf_wdata, 32'hFFFF_FF80);
    chk("lb_we", {31'b0, wb_rf_we}, 32'h1);
    issue(1'b1, 32'h10C, 1'b1, 5'd6, 32'h0000_1003, 1'b1, OP_LBU);
    tick(); #1;
    chk("lbu_stallreq", {31'b0, stallreq_mem}, 32'h0);
    chk("lbu_wdata", wb_rf_wdata, 32'h0000_0080);
    issue(1'b1, 32'h110, 1'b1, 5'd6, 32'h0000_4002, 1'b1, OP_LH);
    tick(); data_rdata = 32'h8001_0000; #1;
    chk("lh_wdata", wb_rf_wdata, 32'hFFFF_8001);

    // LW with 3-cycle response latency
    issue(1'b1, 32'h114, 1'b1, 5'd7, 32'h0000_2000, 1'b1, OP_LW);
    tick(); nop(); data_rvalid = 1'b0; stall = S_HOLD; #1;
    chk("lw_stall1", {31'b0, stallreq_mem}, 32'h1);
    chk("lw_valid1", {31'b0, wb_valid}, 32'h0);
    chk("lw_we1", {31'b0, wb_rf_we}, 32'h0);
    tick();
    chk("lw_stall2", {31'b0, stallreq_mem}, 32'h1);
    tick();
    chk("lw_stall3", {31'b0, stallreq_mem}, 32'h1);
    tick(); data_rvalid = 1'b1; data_rdata = 32'hDEAD_BEEF; stall = '0; #1;
    chk("lw_resp_stall", {31'b0, stallreq_mem}, 32'h0);
    chk("lw_resp_valid", {31'b0, wb_valid}, 32'h1);
    chk("lw_resp_wdata", wb_rf_wdata, 32'hDEAD_BEEF);
    chk("lw_resp_waddr", {27'b0, wb_rf_waddr}, 32'd7);
    chk("lw_resp_we", {31'b0, wb_rf_we}, 32'h1);
    tick(); data_rvalid = 1'b0; #1;
    chk("lw_after_valid", {31'b0, wb_valid}, 32'h0);
    chk("lw_after_stall", {31'b0, stallreq_mem}, 32'h0);

    // misaligned loads
    issue(1'b1, 32'h118, 1'b1, 5'd8, 32'h0000_3001, 1'b1, OP_LH);
    tick(); nop(); #1;
    chk("ale_flag", {31'b0, mem_ale}, 32'h1);
    chk("ale_we", {31'b0, wb_rf_we}, 32'h0);
    chk("ale_stall", {31'b0, stallreq_mem}, 32'h0);
    tick();
    chk("ale_no_wait", {31'b0, stallreq_mem}, 32'h0);
    issue(1'b1, 32'h11C, 1'b1, 5'd8, 32'h0000_3000, 1'b1, OP_LD);
    tick(); nop(); #1;
    chk("ld32_ale", {31'b0, mem_ale}, 32'h1);
    chk("ld32_stall", {31'b0, stallreq_mem}, 32'h0);
    tick();

    // response under stall is held in the buffer
    issue(1'b1, 32'h120, 1'b1, 5'd9, 32'h0000_4002, 1'b1, OP_LHU);
    tick(); nop(); data_rvalid = 1'b1; data_rdata = 32'h8001_0000; stall = S_HOLD; #1;
    chk("held0_wdata", wb_rf_wdata, 32'h0000_8001);
    chk("held0_stall", {31'b0, stallreq_mem}, 32'h0);
    tick(); data_rvalid = 1'b0; data_rdata = 32'hFFFF_FFFF; #1;
    chk("held1_wdata", wb_rf_wdata, 32'h0000_8001);
    chk("held1_valid", {31'b0, wb_valid}, 32'h1);
    tick();
    chk("held2_wdata", wb_rf_wdata, 32'h0000_8001);
    chk("held2_stall", {31'b0, stallreq_mem}, 32'h0);
    stall = '0; #1;
    chk("held_rel_wdata", wb_rf_wdata, 32'h0000_8001);
    tick(); data_rdata = '0;
    chk("held_done_valid", {31'b0, wb_valid}, 32'h0);

    // asynchronous reset while a load is outstanding
    issue(1'b1, 32'h200, 1'b1, 5'd10, 32'h0000_5000, 1'b1, OP_LW);
    tick(); nop(); stall = S_HOLD; #1;
    chk("rw_stall_idle", {31'b0, stallreq_mem}, 32'h1);
    tick();
    chk("rw_stall_wait", {31'b0, stallreq_mem}, 32'h1);
    rst = 1'b1; #1;
    chk("rw_stallreq", {31'b0, stallreq_mem}, 32'h0);
    chk("rw_valid", {31'b0, wb_valid}, 32'h0);
    chk("rw_pc", wb_pc, 32'h0);
    chk("rw_waddr", {27'b0, wb_rf_waddr}, 32'h0);
    chk("rw_wdata", wb_rf_wdata, 32'h0);
    chk("rw_we", {31'b0, wb_rf_we}, 32'h0);
    rst = 1'b0; stall = '0; data_rvalid = 1'b1; data_rdata = 32'h1234_5678; #1;
    chk("rw_late_valid", {31'b0, wb_valid}, 32'h0);
    chk("rw_late_we", {31'b0, wb_rf_we}, 32'h0);
    tick(); data_rvalid = 1'b0; #1;
    chk("rw_post_stall", {31'b0, stallreq_mem}, 32'h0);
    chk("rw_post_valid", {31'b0, wb_valid}, 32'h0);

    // flush during WAIT beats stall and returns to idle
    issue(1'b1, 32'h300, 1'b1, 5'd11, 32'h0000_6000, 1'b1, OP_LW);
    tick(); nop(); stall = S_HOLD; #1;
    tick(); flush = 1'b1; #1;
    chk("fl_pre_stall", {31'b0, stallreq_mem}, 32'h1);
    tick(); flush = 1'b0; stall = '0; #1;
    chk("fl_valid", {31'b0, wb_valid}, 32'h0);
    chk("fl_stall", {31'b0, stallreq_mem}, 32'h0);
    issue(1'b1, 32'h304, 1'b1, 5'd12, 32'h0000_00AB, 1'b0, OP_LB);
    tick(); nop(); #1;
    chk("fl_next_wdata", wb_rf_wdata, 32'h0000_00AB);
    chk("fl_next_we", {31'b0, wb_rf_we}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
